vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator; next-generation replacement for the fixed 640x480 controller.
//  Generalises porch/sync/active sizes, sync polarity and pixel-clock division.
//  Adds a run enable, frame/line strobes and a configurable sync/blank delay to align with a pipelined pixel path.
//  Sits between the system clock and the game's pixel generator; videoGen consumes x/y, the DAC consumes sync/blank.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   horizontal sync width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      11   vertical front porch (lines)
//  V_SYNC    2    vertical sync width (lines)
//  V_BP      32   vertical back porch (lines)
//  CLK_DIV   2    clk cycles per pixel, >=1 (2: 50 MHz -> 25 MHz pixel rate)
//  HS_POL    0    hsync active level (0 = active-low)
//  VS_POL    0    vsync active level (0 = active-low)
//  PIPE      1    pixel ticks of delay on hsync/vsync/blank_b vs x/y, 0..4
//  CW        10   counter / coordinate width
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high
//  en           in   1   run enable; 0 freezes divider and counters
//  pix_ce       out  1   one-clk pulse per pixel tick
//  x            out  CW  current horizontal count (0..HMAX-1)
//  y            out  CW  current vertical count (0..VMAX-1)
//  hsync        out  1   horizontal sync, polarity HS_POL, delayed PIPE ticks
//  vsync        out  1   vertical sync, polarity VS_POL, delayed PIPE ticks
//  blank_b      out  1   1 = active video, delayed PIPE ticks
//  sync_b       out  1   tied 0
//  line_start   out  1   one-clk pulse on the tick where x wraps to 0
//  frame_start  out  1   one-clk pulse on the tick where (x,y) wraps to (0,0)
//  vblank       out  1   y >= V_ACTIVE (undelayed)
// BEHAVIOUR
//  HMAX = H_ACTIVE+H_FP+H_SYNC+H_BP; VMAX = V_ACTIVE+V_FP+V_SYNC+V_BP.
//  Line order: active, FP, sync, BP. Frame order is the same.
//  Reset values:
//   - divider, x, y = 0; pix_ce, line_start, frame_start = 0.
//   - hsync = ~HS_POL, vsync = ~VS_POL; blank_b = 0; vblank = 0.
//   - all PIPE delay stages load their inactive values.
//  Divider:
//   - 0..CLK_DIV-1, counts only while en=1.
//   - pix_ce=1 in the clk where divider==CLK_DIV-1 and en=1.
//   - CLK_DIV=1 gives pix_ce=en.
//  Counters advance only on pix_ce:
//   - x increments; at HMAX-1, x->0 and y increments.
//   - at y==VMAX-1 and x==HMAX-1, y->0.
//   - x never equals HMAX; y never equals VMAX.
//  Raw decode from the current x/y:
//   - hs_raw = x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//   - vs_raw = y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
//   - act = x<H_ACTIVE & y<V_ACTIVE.
//  Delay:
//   - hs/vs/act pass through a PIPE-deep shift register clocked on pix_ce.
//   - outputs apply polarity: hsync = hs_d ? HS_POL : ~HS_POL.
//   - PIPE=0: outputs are registered decodes of the current x/y, valid the same clk as x/y.
//  Strobes:
//   - line_start = pix_ce & x==HMAX-1.
//   - frame_start = line_start & y==VMAX-1.
//   - registered outputs, so each pulse is visible the clk after the wrapping tick, coincident with x=0.
//   - first frame_start after reset arrives after HMAX*VMAX pixel ticks.
//  en deasserted mid-line: all state holds, no strobes; resumes exactly where it stopped.
//  reset mid-frame: immediate return to reset values; the first tick after release is x=1.
// TESTING
//  1. Defaults, en=1 from reset: frame_start period = 800*525*2 = 840000 clk; line_start period = 1600 clk.
//  2. Defaults: hsync low for 96 ticks (192 clk), starting 656+PIPE ticks after x=0; vsync low for exactly 2 lines starting at line 491+PIPE-delay.
//  3. Small params (H 8/2/2/2, V 4/1/1/1, CLK_DIV=1, PIPE=0): blank_b=1 exactly for x<8 & y<4; x wraps 13->0; y wraps 6->0.
//  4. HS_POL=1, VS_POL=1: hsync/vsync idle low after reset and pulse high with the same widths as case 2.
//  5. en dropped at x=100 for 50 clk: x stays 100, no pix_ce or strobes; resumes at 101 when en returns.
//  6. reset pulsed at x=300, y=200: all outputs reach reset values asynchronously; counting restarts from (0,0).

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parametrised VGA raster timing generator. Divides the system
//             clock down to a pixel tick, walks an x/y raster (active, front
//             porch, sync, back porch in both directions) and produces
//             sync/blank with a configurable pixel-tick delay so they line up
//             with a pipelined pixel path.
//  Ports    : clk          system clock
//             reset        asynchronous, active-high
//             en           run enable; low freezes divider and counters
//             pix_ce       one-clk pulse per pixel tick
//             x, y         current raster coordinates
//             hsync/vsync  syncs with selectable polarity, delayed PIPE ticks
//             blank_b      1 = active video, delayed PIPE ticks
//             sync_b       composite sync for the DAC, unused (tied 0)
//             line_start   one-clk pulse coincident with x = 0
//             frame_start  one-clk pulse coincident with (x,y) = (0,0)
//             vblank       y >= V_ACTIVE, undelayed
//  Revision : 1.0  initial parametrised release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 11,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 32,
    parameter int CLK_DIV  = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE     = 1,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          pix_ce,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          blank_b,
    output logic          sync_b,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank
);

    localparam int c_HMAX = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_VMAX = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   c_X_LAST   = CW'(c_HMAX - 1);
    localparam logic [CW-1:0]   c_Y_LAST   = CW'(c_VMAX - 1);
    localparam logic [CW-1:0]   c_H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0]   c_V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0]   c_HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0]   c_HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0]   c_VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0]   c_VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    // Bit positions inside one delay-line stage
    localparam int c_B_HS  = 2;
    localparam int c_B_VS  = 1;
    localparam int c_B_ACT = 0;

    logic [c_DW-1:0] r_div;
    logic [CW-1:0]   r_x;
    logic [CW-1:0]   r_y;
    logic            r_line_start;
    logic            r_frame_start;
    // Stage 0 always holds the decode of the current x/y; stage PIPE drives
    // the outputs, so PIPE=0 gives decodes aligned with x/y.
    logic [2:0]      r_pipe [0:PIPE];

    logic            w_tick;
    logic            w_x_last;
    logic            w_y_last;
    logic [CW-1:0]   w_x_nxt;
    logic [CW-1:0]   w_y_nxt;
    logic [2:0]      w_dec_nxt;

    // ------------------------------------------------------------------
    // Pixel divider. Reset is folded into the tick so pix_ce reads 0 while
    // reset is held, even with CLK_DIV=1 and en high.
    // ------------------------------------------------------------------
    assign w_tick = en & ~reset & (r_div == c_DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (en) begin
            r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + c_DW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Raster counters and their next values
    // ------------------------------------------------------------------
    assign w_x_last = (r_x == c_X_LAST);
    assign w_y_last = (r_y == c_Y_LAST);
    assign w_x_nxt  = w_x_last ? '0 : r_x + CW'(1);
    assign w_y_nxt  = w_x_last ? (w_y_last ? '0 : r_y + CW'(1)) : r_y;

    // Decoding the next position and registering it on the tick makes the
    // stage-0 value valid in the same clk as the new x/y.
    always_comb begin
        w_dec_nxt          = '0;
        w_dec_nxt[c_B_HS]  = (w_x_nxt >= c_HS_START) && (w_x_nxt < c_HS_END);
        w_dec_nxt[c_B_VS]  = (w_y_nxt >= c_VS_START) && (w_y_nxt < c_VS_END);
        w_dec_nxt[c_B_ACT] = (w_x_nxt < c_H_ACT) && (w_y_nxt < c_V_ACT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
            for (int i = 0; i <= PIPE; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (w_tick) begin
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_pipe[0] <= w_dec_nxt;
            for (int i = 1; i <= PIPE; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Strobes: registered every clk so they are single-clk pulses that
    // appear together with the wrapped coordinate.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_tick & w_x_last;
            r_frame_start <= w_tick & w_x_last & w_y_last;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pix_ce      = w_tick;
    assign x           = r_x;
    assign y           = r_y;
    assign hsync       = r_pipe[PIPE][c_B_HS] ? HS_POL : ~HS_POL;
    assign vsync       = r_pipe[PIPE][c_B_VS] ? VS_POL : ~VS_POL;
    assign blank_b     = r_pipe[PIPE][c_B_ACT];
    assign sync_b      = 1'b0;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign vblank      = (r_y >= c_V_ACT);

endmodule
`default_nettype wire
